// File: rtl/dendrite_accum_if.sv
// Spike-event handshake and soma-facing result bus for dendrite_accum.
interface dendrite_accum_if #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned W_W   = 8
) ();
    logic             ev_valid;
    logic [IDX_W-1:0] ev_idx;
    logic             ev_ready;
    logic             out_valid;
    logic [W_W-1:0]   weight_out;
    logic [7:0]       dt_out;

    modport master (
        output ev_valid, ev_idx,
        input  ev_ready, out_valid, weight_out, dt_out
    );

    modport slave (
        input  ev_valid, ev_idx,
        output ev_ready, out_valid, weight_out, dt_out
    );
endinterface

// File: rtl/dendrite_accum.sv
// Dendrite accumulator: per-step saturating sum of synapse weights, emitted on tick.
// Optional macro DENDRITE_SAT_FLAG_EN adds a sat_flag output.
module dendrite_accum #(
    parameter int unsigned N_SYN = 16,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned W_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [W_W-1:0]   cfg_wdata,
    input  logic             tick,
    output logic             busy,
`ifdef DENDRITE_SAT_FLAG_EN
    output logic             sat_flag,
`endif
    dendrite_accum_if.slave  ev
);

    localparam int unsigned A_W = (N_SYN > 1) ? $clog2(N_SYN) : 1;

    typedef enum logic [1:0] {
        ACCUM,
        FLUSH,
        DISABLED
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [W_W-1:0] table_q [N_SYN];
    logic [W_W-1:0] rd_w;
    logic           pipe_v;
    logic [W_W-1:0] acc;
    logic [7:0]     dt;

    logic           accept;
    logic           ev_in_range;
    logic           cfg_in_range;
    logic [W_W:0]   sum_wide;
    logic [W_W-1:0] sum_sat;
    logic           sum_ovf;
    logic [7:0]     dt_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        ev.ev_ready = 1'b0;
        busy        = 1'b0;
        case (state)
            ACCUM: begin
                ev.ev_ready = !kill;
                if (kill) begin
                    state_next = DISABLED;
                end else if (tick) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = kill ? DISABLED : ACCUM;
            end
            DISABLED: begin
                state_next = DISABLED;
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    always_comb begin
        accept       = ev.ev_valid && ev.ev_ready;
        ev_in_range  = 32'(ev.ev_idx) < N_SYN;
        cfg_in_range = 32'(cfg_addr) < N_SYN;
        sum_wide     = {1'b0, acc} + {1'b0, (pipe_v ? rd_w : '0)};
        sum_ovf      = sum_wide[W_W];
        sum_sat      = sum_ovf ? '1 : sum_wide[W_W-1:0];
        dt_inc       = (dt == 8'hFF) ? dt : dt + 8'd1;
    end

    // Nonblocking write alongside the lookup read gives read-before-write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_SYN; i++) begin
                table_q[i] <= '0;
            end
        end else if (cfg_we && cfg_in_range) begin
            table_q[cfg_addr[A_W-1:0]] <= cfg_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_w <= '0;
        end else if (accept) begin
            rd_w <= ev_in_range ? table_q[ev.ev_idx[A_W-1:0]] : '0;
        end
    end

    // The FLUSH cycle folds in the last in-flight weight and emits directly
    // from that combined sum, so the tick-cycle event lands in the closing step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_v        <= 1'b0;
            acc           <= '0;
            dt            <= '0;
            ev.out_valid  <= 1'b0;
            ev.weight_out <= '0;
            ev.dt_out     <= '0;
        end else begin
            ev.out_valid <= 1'b0;
            pipe_v       <= accept;
            case (state)
                ACCUM: begin
                    if (kill) begin
                        acc    <= '0;
                        pipe_v <= 1'b0;
                    end else if (pipe_v) begin
                        acc <= sum_sat;
                    end
                end
                FLUSH: begin
                    if (kill) begin
                        acc    <= '0;
                        pipe_v <= 1'b0;
                    end else if (sum_sat != '0) begin
                        ev.out_valid  <= 1'b1;
                        ev.weight_out <= sum_sat;
                        ev.dt_out     <= dt_inc;
                        acc           <= '0;
                        dt            <= '0;
                    end else begin
                        acc <= '0;
                        dt  <= dt_inc;
                    end
                end
                default: begin
                    acc    <= '0;
                    pipe_v <= 1'b0;
                end
            endcase
        end
    end

`ifdef DENDRITE_SAT_FLAG_EN
    logic sat_seen;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_seen <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            sat_flag <= 1'b0;
            case (state)
                ACCUM: begin
                    if (kill) begin
                        sat_seen <= 1'b0;
                    end else if (pipe_v && sum_ovf) begin
                        sat_seen <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (!kill && sum_sat != '0) begin
                        sat_flag <= sat_seen || sum_ovf;
                    end
                    sat_seen <= 1'b0;
                end
                default: begin
                    sat_seen <= 1'b0;
                end
            endcase
        end
    end
`endif

endmodule
